pipe_scheduler: RTL and testbench

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

---
 rtl/pipe_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Purpose: spawns, scrolls, scores and collision-checks up to three pipes per VGA frame.
// Latency: frame_tick at cycle N -> pipe positions at N+1, score/hit/upd_done at N+2.
// Backpressure: none; frame_tick outside RUN is dropped (not queued), FROZEN holds all outputs.
module pipe_scheduler #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PIPE_W   = 60,
  parameter int unsigned GAP_H    = 120,
  parameter int unsigned GAP_MIN  = 40,
  parameter int unsigned SPACING  = 220,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned BIRD_X   = 160,
  parameter int unsigned BIRD_W   = 20,
  parameter int unsigned BIRD_H   = 20
) (
  input  logic        CLK,
  input  logic        SW,
  input  logic        frame_tick,
  input  logic [2:0]  state,
  input  logic [9:0]  bird_y,
  output logic [2:0]  pipe_valid,
  output logic [32:0] pipe_x,
  output logic [29:0] gap_y,
  output logic        hit,
  output logic [7:0]  score,
  output logic        upd_done
);

  // Game-state encodings driven by the game controller.
  localparam logic [2:0] GS_BEGIN = 3'b100;
  localparam logic [2:0] GS_DOWN  = 3'b001;
  localparam logic [2:0] GS_UP    = 3'b010;
  localparam logic [2:0] GS_DEAD  = 3'b011;

  // Geometry constants sized to the arithmetic they take part in.
  localparam logic [10:0] SCR_W   = 11'(SCREEN_W);
  localparam logic [10:0] SPC     = 11'(SPACING);
  localparam logic [10:0] SPD     = 11'(SPEED);
  localparam logic [11:0] PW12    = 12'(PIPE_W);
  localparam logic [11:0] BX12    = 12'(BIRD_X);
  localparam logic [11:0] BIRD_R  = 12'(BIRD_X + BIRD_W);
  localparam logic [10:0] GH11    = 11'(GAP_H);
  localparam logic [10:0] BH11    = 11'(BIRD_H);
  localparam logic [10:0] SCR_H11 = 11'(SCREEN_H);
  localparam logic [9:0]  GMIN    = 10'(GAP_MIN);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_FROZEN} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [2:0]       valid_q, valid_d;
  logic [2:0][10:0] x_q, x_d;
  logic [2:0][9:0]  gap_q, gap_d;
  logic [2:0]       scored_q, scored_d;
  logic [10:0]      cnt_q, cnt_d;
  logic [7:0]       score_q, score_d;
  logic             hit_q, hit_d;
  logic             dead_q, dead_d;
  logic             upd_q, upd_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic [2:0]       passed;
  logic [2:0]       collide;
  logic [10:0]      bird_bot;
  logic             ground;
  logic             free_found;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Game FSM state register.
  always_ff @(posedge CLK) begin
    if (SW) fsm_q <= S_IDLE;
    else    fsm_q <= fsm_d;
  end

  // Next FSM state; a BEGIN request overrides everything, a death seen mid-update freezes after CHECK.
  always_comb begin
    fsm_d = fsm_q;
    if (state == GS_BEGIN) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE:   if (state == GS_DOWN || state == GS_UP) fsm_d = S_RUN;
        S_RUN:    if (state == GS_DEAD) fsm_d = S_FROZEN;
                  else if (frame_tick) fsm_d = S_MOVE;
        S_MOVE:   fsm_d = S_CHECK;
        S_CHECK:  fsm_d = (dead_q || state == GS_DEAD) ? S_FROZEN : S_RUN;
        S_FROZEN: fsm_d = S_FROZEN;
        default:  fsm_d = S_IDLE;
      endcase
    end
  end

  // Per-slot geometry on the current (post-move) positions: passed the bird, or overlapping it outside the gap.
  always_comb begin
    bird_bot = {1'b0, bird_y} + BH11;
    ground   = (bird_bot >= SCR_H11);
    for (int i = 0; i < 3; i++) begin
      passed[i]  = ({1'b0, x_q[i]} + PW12) < BX12;
      collide[i] = valid_q[i]
                 && ({1'b0, x_q[i]} < BIRD_R)
                 && (({1'b0, x_q[i]} + PW12) > BX12)
                 && ((bird_y < gap_q[i]) || (bird_bot > ({1'b0, gap_q[i]} + GH11)));
    end
  end

  // Datapath next state: clear in IDLE, scroll/spawn in MOVE, score/collide in CHECK, hold otherwise.
  always_comb begin
    valid_d    = valid_q;
    x_d        = x_q;
    gap_d      = gap_q;
    scored_d   = scored_q;
    cnt_d      = cnt_q;
    score_d    = score_q;
    hit_d      = hit_q;
    dead_d     = dead_q;
    upd_d      = 1'b0;
    free_found = 1'b0;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (state == GS_BEGIN || fsm_q == S_IDLE) begin
      valid_d  = '0;
      scored_d = '0;
      score_d  = 8'h00;
      hit_d    = 1'b0;
      dead_d   = 1'b0;
      cnt_d    = SPC;
    end else if (fsm_q == S_MOVE) begin
      // A slot whose left edge would wrap below zero is retired before it moves.
      for (int i = 0; i < 3; i++) begin
        if (valid_q[i]) begin
          if (x_q[i] < SPD) begin
            valid_d[i]  = 1'b0;
            scored_d[i] = 1'b0;
          end else begin
            x_d[i] = x_q[i] - SPD;
          end
        end
      end
      // Spawn decision uses the pre-increment distance; a freshly retired slot is reusable at once.
      if (cnt_q >= SPC) begin
        for (int i = 0; i < 3; i++) begin
          if (!free_found && !valid_d[i]) begin
            free_found  = 1'b1;
            valid_d[i]  = 1'b1;
            scored_d[i] = 1'b0;
            x_d[i]      = SCR_W;
            gap_d[i]    = GMIN + {2'b00, lfsr_q};
          end
        end
        cnt_d = free_found ? 11'd0 : SPC;
      end else if (cnt_q + SPD >= SPC) begin
        cnt_d = SPC;
      end else begin
        cnt_d = cnt_q + SPD;
      end
      dead_d = (state == GS_DEAD);
    end else if (fsm_q == S_CHECK) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_q[i] && !scored_q[i] && passed[i]) begin
          scored_d[i] = 1'b1;
          score_d     = bcd_inc(score_d);
        end
      end
      hit_d  = hit_q | (|collide) | ground;
      upd_d  = 1'b1;
      dead_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (SW) begin
      valid_q  <= '0;
      x_q      <= '0;
      gap_q    <= '0;
      scored_q <= '0;
      cnt_q    <= SPC;
      score_q  <= 8'h00;
      hit_q    <= 1'b0;
      dead_q   <= 1'b0;
      upd_q    <= 1'b0;
      lfsr_q   <= 8'h5A;
    end else begin
      valid_q  <= valid_d;
      x_q      <= x_d;
      gap_q    <= gap_d;
      scored_q <= scored_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      dead_q   <= dead_d;
      upd_q    <= upd_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign pipe_valid = valid_q;
  assign pipe_x     = x_q;
  assign gap_y      = gap_q;
  assign hit        = hit_q;
  assign score      = score_q;
  assign upd_done   = upd_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Purpose: directed scoreboard bench for pipe_scheduler (spawn, scroll, score, collision, freeze, reset).
// Latency: each frame tick expects an upd_done pulse two cycles after the tick edge.
// Backpressure: ticks are spaced four cycles apart so every tick lands in RUN.
module tb_pipe_scheduler;

  logic        CLK = 1'b0;
  logic        SW;
  logic        frame_tick;
  logic [2:0]  state;
  logic [9:0]  bird_y;
  logic [2:0]  pipe_valid;
  logic [32:0] pipe_x;
  logic [29:0] gap_y;
  logic        hit;
  logic [7:0]  score;
  logic        upd_done;

  typedef struct packed {
    logic [7:0] score;
    logic       hit;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         wait_cnt = 0;
  int         gt;
  int         npass;
  bit         exp_hit;
  bit         bird_ovr;
  logic [9:0] bird_val;
  logic [7:0] m_lfsr;
  logic [9:0] gaps [0:127];

  pipe_scheduler dut (
    .CLK        (CLK),
    .SW         (SW),
    .frame_tick (frame_tick),
    .state      (state),
    .bird_y     (bird_y),
    .pipe_valid (pipe_valid),
    .pipe_x     (pipe_x),
    .gap_y      (gap_y),
    .hit        (hit),
    .score      (score),
    .upd_done   (upd_done)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 5A by reset, stepping every clock.
  always @(posedge CLK) begin
    if (SW) m_lfsr <= 8'h5A;
    else    m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [7:0] to_bcd(input int n);
    int r;
    r = n % 100;
    return {4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every upd_done pulse pops one expected {score,hit}; stray pulses and stalls count as failures.
  always @(negedge CLK) begin
    if (upd_done === 1'b1) begin
      n_vec++;
      wait_cnt = 0;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_upd_done: got pulse (score %0h hit %0b), expected none", score, hit);
      end else begin
        mon_e = sb_q.pop_front();
        if (score !== mon_e.score || hit !== mon_e.hit) begin
          n_err++;
          $display("FAIL frame_result: got score %0h hit %0b, expected score %0h hit %0b",
                   score, hit, mon_e.score, mon_e.hit);
        end
      end
    end else if (sb_q.size() != 0) begin
      wait_cnt++;
      if (wait_cnt > 8) begin
        n_vec++;
        n_err++;
        $display("FAIL upd_done_timeout: got no pulse in 8 cycles, expected one");
        void'(sb_q.pop_front());
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One game frame: pick bird height, predict the result, pulse frame_tick, record any spawned gap.
  // Pipe k spawns on game tick 1+111k, overlaps the bird on its moves 231..269 and scores on move 271.
  task automatic tick();
    exp_t ex;
    int   k;
    gt++;
    if (bird_ovr) bird_y = bird_val;
    else if (gt == 1) bird_y = 10'd200;
    else begin
      k = (gt > 201) ? (gt - 201) / 111 : 0;
      bird_y = gaps[k] + 10'd50;
    end
    if (gt >= 272 && (gt - 272) % 111 == 0) npass++;
    ex.score = to_bcd(npass);
    ex.hit   = exp_hit;
    sb_q.push_back(ex);
    frame_tick = 1'b1;
    @(posedge CLK); #1;
    frame_tick = 1'b0;
    if ((gt - 1) % 111 == 0) gaps[(gt - 1) / 111] = 10'd40 + {2'b00, m_lfsr};
    @(posedge CLK); #1;
    if (gt == 1) begin
      check("first_spawn_valid", pipe_valid, 3'b001);
      check("first_spawn_x", pipe_x[10:0], 11'd640);
      check("first_spawn_gap", gap_y[9:0], gaps[0]);
      check("first_spawn_no_early_done", upd_done, 1'b0);
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic bare_pulse();
    frame_tick = 1'b1;
    @(posedge CLK); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic new_game();
    gt       = 0;
    npass    = 0;
    exp_hit  = 1'b0;
    bird_ovr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    SW         = 1'b1;
    frame_tick = 1'b0;
    state      = 3'b100;
    bird_y     = 10'd200;
    bird_val   = 10'd0;
    repeat (3) @(posedge CLK);
    #1;
    SW = 1'b0;
    check("reset_valid", pipe_valid, 3'b000);
    check("reset_x", pipe_x, 33'd0);
    check("reset_gap", gap_y, 30'd0);
    check("reset_score", score, 8'h00);
    check("reset_hit", hit, 1'b0);
    check("reset_upd", upd_done, 1'b0);

    // Game 1: spawn cadence, first score, collision, freeze, clear.
    state = 3'b001;
    @(posedge CLK); #1;
    new_game();
    repeat (111) tick();
    check("slot0_after_110_ticks", pipe_x[10:0], 11'd420);
    check("one_pipe_after_110_ticks", pipe_valid, 3'b001);
    tick();
    check("second_spawn_valid", pipe_valid, 3'b011);
    check("second_spawn_x1", pipe_x[21:11], 11'd640);
    check("second_spawn_x0", pipe_x[10:0], 11'd418);
    check("second_spawn_gap", gap_y[19:10], gaps[1]);
    while (gt < 342) begin
      tick();
      if (gt == 271) check("score_before_pass", score, 8'h00);
      if (gt == 272) check("score_first_pass", score, 8'h01);
      if (gt == 275) check("score_single_increment", score, 8'h01);
    end
    bird_ovr = 1'b1;
    bird_val = 10'd0;
    exp_hit  = 1'b1;
    tick();
    check("collide_hit", hit, 1'b1);
    check("slots_at_collision", pipe_x, {11'd400, 11'd178, 11'd622});
    check("valid_at_collision", pipe_valid, 3'b111);

    state  = 3'b011;
    repeat (2) @(posedge CLK);
    #1;
    bird_y = 10'd460;
    repeat (3) bare_pulse();
    check("frozen_x", pipe_x, {11'd400, 11'd178, 11'd622});
    check("frozen_gap", gap_y, {gaps[2], gaps[1], gaps[3]});
    check("frozen_score", score, 8'h01);
    check("frozen_hit", hit, 1'b1);

    state = 3'b100;
    repeat (2) @(posedge CLK);
    #1;
    check("clear_valid", pipe_valid, 3'b000);
    check("clear_score", score, 8'h00);
    check("clear_hit", hit, 1'b0);
    bare_pulse();
    state = 3'b001;
    repeat (6) @(posedge CLK);
    #1;
    check("idle_tick_dropped", pipe_valid, 3'b000);

    // Game 2: play through 100 pipes so the score wraps, then the ground boundary.
    new_game();
    while (gt < 11261) begin
      tick();
      if (gt == 11150) check("score_99", score, 8'h99);
    end
    check("score_wrap", score, 8'h00);
    bird_ovr = 1'b1;
    bird_val = 10'd459;
    tick();
    check("ground_margin_no_hit", hit, 1'b0);
    bird_val = 10'd460;
    exp_hit  = 1'b1;
    tick();
    check("ground_hit", hit, 1'b1);

    // Reset lands on the MOVE cycle: update aborted, no pulse.
    frame_tick = 1'b1;
    @(posedge CLK); #1;
    frame_tick = 1'b0;
    SW = 1'b1;
    @(posedge CLK); #1;
    SW = 1'b0;
    check("midreset_valid", pipe_valid, 3'b000);
    check("midreset_x", pipe_x, 33'd0);
    check("midreset_gap", gap_y, 30'd0);
    check("midreset_score", score, 8'h00);
    check("midreset_hit", hit, 1'b0);
    check("midreset_upd", upd_done, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
